// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a head entry plus a skid entry so that
// in_ready comes straight from a flop while still sustaining one transfer per cycle.
module pipe_stage_skid #(
  parameter int unsigned       DATA_W    = 200,
  parameter int unsigned       SIG_W     = 16,
  parameter logic [DATA_W-1:0] KEEP_MASK = {DATA_W{1'b0}},
  parameter int unsigned       CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              CLR,
  input  logic              EN,
  input  logic              bb,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SIG_W-1:0]  in_sig,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [SIG_W-1:0]  out_sig,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) begin
      sat_inc = c;
    end else begin
      sat_inc = c + CNT_W'(1);
    end
  endfunction

  function automatic logic [1:0] occ_of(input logic h, input logic s);
    occ_of = {1'b0, h} + {1'b0, s};
  endfunction

  logic              head_valid_q, head_valid_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] head_data_q,  head_data_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic [SIG_W-1:0]  head_sig_q,   head_sig_d;
  logic [SIG_W-1:0]  skid_sig_q,   skid_sig_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              in_ready_q,   in_ready_d;
  logic [1:0]        occ_q,        occ_d;
  logic              in_fire_s;
  logic              out_fire_s;

  assign in_fire_s  = in_valid & in_ready_q & EN & ~CLR;
  assign out_fire_s = head_valid_q & out_ready & EN & ~CLR & ~bb;

  // Next-state: flush > stall > squash > handshake.
  always_comb begin
    head_valid_d = head_valid_q;
    skid_valid_d = skid_valid_q;
    head_data_d  = head_data_q;
    skid_data_d  = skid_data_q;
    head_sig_d   = head_sig_q;
    skid_sig_d   = skid_sig_q;
    cnt_d        = cnt_q;
    if (CLR) begin
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      head_data_d  = {DATA_W{1'b0}};
      skid_data_d  = {DATA_W{1'b0}};
      head_sig_d   = {SIG_W{1'b0}};
      skid_sig_d   = {SIG_W{1'b0}};
    end else if (!EN) begin
      head_valid_d = head_valid_q;
    end else if (bb) begin
      if (skid_valid_q) begin
        head_valid_d = 1'b1;
        head_data_d  = skid_data_q;
        head_sig_d   = skid_sig_q;
        skid_valid_d = 1'b0;
        skid_data_d  = {DATA_W{1'b0}};
        skid_sig_d   = {SIG_W{1'b0}};
      end else if (in_fire_s) begin
        head_valid_d = 1'b1;
        head_data_d  = in_data;
        head_sig_d   = in_sig;
      end else begin
        // Squashed head keeps only the masked payload residue.
        head_valid_d = 1'b0;
        head_sig_d   = {SIG_W{1'b0}};
        head_data_d  = head_data_q & KEEP_MASK;
      end
      if (head_valid_q) begin
        cnt_d = sat_inc(cnt_q);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      case ({head_valid_q, skid_valid_q})
        2'b00: begin
          if (in_fire_s) begin
            head_valid_d = 1'b1;
            head_data_d  = in_data;
            head_sig_d   = in_sig;
          end else begin
            head_valid_d = 1'b0;
          end
        end
        2'b10: begin
          if (in_fire_s && out_fire_s) begin
            head_data_d = in_data;
            head_sig_d  = in_sig;
          end else if (in_fire_s) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
            skid_sig_d   = in_sig;
          end else if (out_fire_s) begin
            head_valid_d = 1'b0;
            head_sig_d   = {SIG_W{1'b0}};
            head_data_d  = head_data_q & KEEP_MASK;
          end else begin
            head_valid_d = 1'b1;
          end
        end
        2'b11: begin
          if (out_fire_s) begin
            head_data_d  = skid_data_q;
            head_sig_d   = skid_sig_q;
            skid_valid_d = 1'b0;
            skid_data_d  = {DATA_W{1'b0}};
            skid_sig_d   = {SIG_W{1'b0}};
          end else begin
            skid_valid_d = 1'b1;
          end
        end
        default: begin
          // Skid without head cannot arise; promote it so the stage self-heals.
          head_valid_d = skid_valid_q;
          head_data_d  = skid_data_q;
          head_sig_d   = skid_sig_q;
          skid_valid_d = 1'b0;
          skid_data_d  = {DATA_W{1'b0}};
          skid_sig_d   = {SIG_W{1'b0}};
        end
      endcase
    end
    in_ready_d = ~skid_valid_d;
    occ_d      = occ_of(head_valid_d, skid_valid_d);
  end

  // State and registered status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      head_data_q  <= {DATA_W{1'b0}};
      skid_data_q  <= {DATA_W{1'b0}};
      head_sig_q   <= {SIG_W{1'b0}};
      skid_sig_q   <= {SIG_W{1'b0}};
      cnt_q        <= {CNT_W{1'b0}};
      in_ready_q   <= 1'b1;
      occ_q        <= 2'd0;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      head_data_q  <= head_data_d;
      skid_data_q  <= skid_data_d;
      head_sig_q   <= head_sig_d;
      skid_sig_q   <= skid_sig_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      occ_q        <= occ_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = head_valid_q;
  assign out_data   = head_data_q;
  assign out_sig    = head_sig_q;
  assign occupancy  = occ_q;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: the driver queues accepted entries,
// the monitor checks the DUT against an ordered two-deep queue model.
module tb_pipe_stage_skid;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned SIG_W  = 8;
  localparam int unsigned CNT_W  = 2;
  localparam logic [31:0] MASK   = 32'h0000_FFFF;
  localparam int          MAXC   = 3;

  typedef struct packed {
    logic [SIG_W-1:0]  sig;
    logic [DATA_W-1:0] data;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              CLR = 1'b0;
  logic              EN = 1'b0;
  logic              bb = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = 32'd0;
  logic [SIG_W-1:0]  in_sig = 8'd0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [SIG_W-1:0]  out_sig;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .SIG_W(SIG_W), .KEEP_MASK(MASK), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .CLR(CLR), .EN(EN), .bb(bb),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sig(in_sig),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sig(out_sig),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  int          errs = 0;
  int          checks = 0;
  ent_t        mdl_q[$];
  ent_t        pend_q[$];
  int          mdl_cnt = 0;
  logic [31:0] idle_data = 32'd0;
  bit          idle_known = 1'b1;
  ent_t        f, p, d;
  bit          p_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_bubble_cnt", 64'(bubble_cnt), 64'd0);
    chk("rst_out_sig", 64'(out_sig), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
  endtask

  task automatic cyc(input logic en, input logic clr, input logic b, input logic iv,
                     input logic [31:0] dat, input logic [7:0] s, input logic ordy);
    ent_t e;
    @(posedge clk);
    #2;
    EN = en; CLR = clr; bb = b; in_valid = iv; in_data = dat; in_sig = s; out_ready = ordy;
    if (iv && en && !clr && mdl_q.size() < 2) begin
      e.sig  = s;
      e.data = dat;
      pend_q.push_back(e);
    end
  endtask

  // Asserts reset between edges and checks that outputs clear without a clock.
  task automatic do_reset();
    @(posedge clk);
    #2;
    EN = 1'b1; CLR = 1'b0; bb = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1 rst = 1'b1;
    pend_q.delete();
    #1 check_reset_outputs();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  // Monitor: compare DUT state with the model, then advance the model across the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("out_valid", 64'(out_valid), 64'(mdl_q.size() != 0));
      chk("occupancy", 64'(occupancy), 64'(mdl_q.size()));
      chk("in_ready", 64'(in_ready), 64'(mdl_q.size() < 2));
      chk("bubble_cnt", 64'(bubble_cnt), 64'(mdl_cnt));
      if (mdl_q.size() != 0) begin
        f = mdl_q[0];
        chk("out_data", 64'(out_data), 64'(f.data));
        chk("out_sig", 64'(out_sig), 64'(f.sig));
      end else begin
        chk("out_sig_idle", 64'(out_sig), 64'd0);
        if (idle_known) chk("out_data_idle", 64'(out_data), 64'(idle_data));
      end
    end
    if (rst) begin
      mdl_q.delete(); pend_q.delete();
      mdl_cnt = 0; idle_data = 32'd0; idle_known = 1'b1;
    end else if (CLR) begin
      mdl_q.delete(); pend_q.delete();
      idle_data = 32'd0; idle_known = 1'b1;
    end else if (EN) begin
      p_v = pend_q.size() != 0;
      if (p_v) p = pend_q.pop_front();
      if (bb) begin
        if (mdl_q.size() != 0) begin
          d = mdl_q.pop_front();
          if (mdl_cnt < MAXC) mdl_cnt++;
          if (mdl_q.size() == 0 && !p_v) begin
            idle_data = d.data & MASK;
            idle_known = 1'b1;
          end
        end else if (!p_v) begin
          idle_data = idle_data & MASK;
        end
      end else if (out_ready && mdl_q.size() != 0) begin
        d = mdl_q.pop_front();
        if (mdl_q.size() == 0 && !p_v) idle_known = 1'b0;
      end
      if (p_v) mdl_q.push_back(p);
    end else begin
      pend_q.delete();
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2 check_reset_outputs();
    @(posedge clk);
    #2 rst = 1'b0;

    // Streaming at full rate: each value appears one cycle after it is accepted.
    for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'(i), 8'(i), 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b1);

    // Back-pressure fills the skid, then drains in order.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 8'h11, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 8'h22, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hC, 8'h33, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b1);

    // Squash a lone head: masked residue remains, count becomes 1.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 8'hFF, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 8'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);

    // Full stage frozen by EN=0, then flushed by CLR.
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hA, 8'h44, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'hB, 8'h55, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'h77, 8'h77, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h99, 8'h99, 1'b1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b1);

    // Saturating squash count, then asynchronous reset mid-cycle.
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'h100, 8'h01, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'(i + 'h200), 8'(i + 2), 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b0);
    do_reset();

    // Randomised traffic with stalls, flushes and squashes.
    for (int i = 0; i < 1500; i++) begin
      cyc(1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 3),
          1'($urandom_range(0, 99) < 10), 1'($urandom_range(0, 99) < 70),
          32'($urandom), 8'($urandom), 1'($urandom_range(0, 99) < 60));
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
